pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with one branch delay slot; optional halt-on-zero via PC_HALT_ON_ZERO_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  pc_4msb,
    output logic        in_delay_slot,
    output logic        active,
    output logic        jump_ignored
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        active_q, active_d;
    logic        ignored_q, ignored_d;

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign pc_4msb       = pc_plus4[31:28];
    assign in_delay_slot = (state_q == ST_DELAY);
    assign active        = active_q;
    assign jump_ignored  = ignored_q;

    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        target_d  = target_q;
        active_d  = active_q;
        ignored_d = 1'b0;
        if (state_q != ST_HALT && !stall) begin
            case (state_q)
                ST_RUN: begin
                    pc_d = pc_plus4;
                    if (jump_req) begin
                        target_d = jump_target;
                        state_d  = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    // The target was latched when the branch was taken; a jump
                    // issued from the delay slot itself is dropped.
                    ignored_d = jump_req;
                    pc_d      = target_q;
                    state_d   = ST_RUN;
`ifdef PC_HALT_ON_ZERO_EN
                    if (target_q == 32'd0) begin
                        state_d  = ST_HALT;
                        active_d = 1'b0;
                    end
`endif
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            state_q   <= ST_RUN;
            target_q  <= 32'd0;
            active_q  <= 1'b1;
            ignored_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            target_q  <= target_d;
            active_q  <= active_d;
            ignored_q <= ignored_d;
        end
    end

endmodule
